// File: rtl/tick_step_ctrl_pkg.sv
// tick_pkg: shared controller state encoding and debounce length presets for tick_step_ctrl.
package tick_pkg;
    typedef enum logic [1:0] {
        PAUSE = 2'd0,
        RUN   = 2'd1,
        STEP  = 2'd2,
        HALT  = 2'd3
    } ctrl_state_t;
    localparam int DEBOUNCE_SIM   = 4;
    localparam int DEBOUNCE_BOARD = 250_000;
endpackage

// File: rtl/tick_step_ctrl_btn_debounce.sv
// btn_debounce: synchronizes a raw pushbutton, debounces it and emits a one-cycle press pulse.
module btn_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0] cnt;
    logic db, db_d, s;
    assign s = sync[SYNC_STAGES-1];
    assign btn_press = db & ~db_d;
    // the counter only advances while the synchronized level disagrees with the accepted one
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= '0;
            cnt  <= '0;
            db   <= 1'b0;
            db_d <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], btn_raw};
            db_d <= db;
            if (s == db) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                cnt <= '0;
                db  <= s;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/tick_step_ctrl.sv
// tick_step_ctrl: turns divider rising edges into one-cycle cpu_en pulses under run/step/halt control.
// Defining TICK_STEP_CTRL_CNT_EN adds the tick_cnt issued-pulse counter.
module tick_step_ctrl
    import tick_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int SYNC_STAGES     = 2,
    parameter int CNT_W           = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       slow_clk,
    input  logic       run_sw,
    input  logic       step_btn,
    input  logic       halt,
    input  logic       halt_clr,
    output logic       cpu_en,
    output logic [1:0] state_o
`ifdef TICK_STEP_CTRL_CNT_EN
    ,
    output logic [CNT_W-1:0] tick_cnt
`endif
);
    ctrl_state_t state, state_nx;
    logic s_q, s_q_d, rise, step_press;

    btn_debounce #(
        .SYNC_STAGES(SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
        .clk(clk),
        .rst(rst),
        .btn_raw(step_btn),
        .btn_press(step_press)
    );

    assign rise    = s_q & ~s_q_d;
    assign state_o = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q    <= 1'b0;
            s_q_d  <= 1'b0;
            cpu_en <= 1'b0;
        end else begin
            s_q    <= slow_clk;
            s_q_d  <= s_q;
            cpu_en <= rise & (state == RUN || state == STEP) & ~halt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= PAUSE;
        else     state <= state_nx;
    end

    // halt wins everywhere; leaving HALT always lands in PAUSE
    always_comb begin
        state_nx = state;
        if (halt) begin
            state_nx = HALT;
        end else begin
            case (state)
                PAUSE:   state_nx = run_sw ? RUN : (step_press ? STEP : PAUSE);
                RUN:     state_nx = run_sw ? RUN : PAUSE;
                STEP:    state_nx = rise ? PAUSE : STEP;
                HALT:    state_nx = halt_clr ? PAUSE : HALT;
                default: state_nx = PAUSE;
            endcase
        end
    end

`ifdef TICK_STEP_CTRL_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         tick_cnt <= '0;
        else if (cpu_en) tick_cnt <= tick_cnt + 1'b1;
    end
`else
    logic unused_cnt_w;
    assign unused_cnt_w = ^CNT_W;
`endif
endmodule

// File: tb/tb_tick_step_ctrl.sv
// tb_tick_step_ctrl: directed bench for tick_step_ctrl with a 4-cycle slow_clk period and 4-cycle debounce.
module tb_tick_step_ctrl;
    import tick_pkg::*;
    localparam int CNT_W = 4;
    logic clk = 1'b0, rst = 1'b1, slow_clk = 1'b0, run_sw = 1'b0;
    logic step_btn = 1'b0, halt = 1'b0, halt_clr = 1'b0;
    logic cpu_en;
    logic [1:0] state_o;
`ifdef TICK_STEP_CTRL_CNT_EN
    logic [CNT_W-1:0] tick_cnt;
`endif
    int vectors = 0, miscompares = 0;
    logic div_on = 1'b0;
    int div_cnt = 0;
    logic [2:0] rh = '0;
    int pulses, entries, bad;
    logic [1:0] prev_st;

    always #5 clk = ~clk;

    tick_step_ctrl #(
        .DEBOUNCE_CYCLES(DEBOUNCE_SIM),
        .SYNC_STAGES(2),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .slow_clk(slow_clk),
        .run_sw(run_sw),
        .step_btn(step_btn),
        .halt(halt),
        .halt_clr(halt_clr),
        .cpu_en(cpu_en),
        .state_o(state_o)
`ifdef TICK_STEP_CTRL_CNT_EN
        ,
        .tick_cnt(tick_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // rh[0] marks a slow_clk rise driven in this cycle; the matching pulse shows up two cycles later
    task automatic tick();
        @(posedge clk);
        #1;
        rh = {rh[1:0], 1'b0};
        if (div_on) begin
            div_cnt++;
            if (div_cnt == 2) begin
                div_cnt  = 0;
                slow_clk = ~slow_clk;
                rh[0]    = slow_clk;
            end
        end
    endtask

    task automatic observe();
        tick();
        pulses += int'(cpu_en);
        if (state_o == 2'd2 && prev_st != 2'd2) entries++;
        prev_st = state_o;
    endtask

    task automatic clear_obs();
        pulses  = 0;
        entries = 0;
        prev_st = state_o;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // 1: reset then free-run
        tick();
        tick();
        check("rst_state", 32'(state_o), 0);
        check("rst_cpu_en", 32'(cpu_en), 0);
        rst = 1'b0;
        run_sw = 1'b1;
        tick();
        check("run_entry", 32'(state_o), 1);
        div_on = 1'b1;
        pulses = 0;
        for (int i = 0; i < 24; i++) begin
            tick();
            pulses += int'(cpu_en);
            check("run_pulse", 32'(cpu_en), 32'(rh[2]));
        end
        check("run_pulse_count", 32'(pulses), 6);

        // 2: bouncy press held high -> one step, one pulse
        run_sw = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("pause_state", 32'(state_o), 0);
        clear_obs();
        for (int i = 0; i < 24; i++) begin
            step_btn = (i < 4) ? ~i[0] : (i < 14);
            observe();
        end
        for (int i = 0; i < 10; i++) observe();
        check("step_entries", 32'(entries), 1);
        check("step_pulses", 32'(pulses), 1);
        check("step_return", 32'(state_o), 0);

        // 3: short press is filtered
        clear_obs();
        step_btn = 1'b1;
        observe();
        observe();
        step_btn = 1'b0;
        for (int i = 0; i < 16; i++) observe();
        check("short_entries", 32'(entries), 0);
        check("short_pulses", 32'(pulses), 0);
        check("short_state", 32'(state_o), 0);

        // 4: halt coinciding with a detected edge in RUN
        run_sw = 1'b1;
        tick();
        check("run_again", 32'(state_o), 1);
        bad = 1;
        for (int i = 0; i < 10 && bad == 1; i++) begin
            tick();
            if (rh[1]) bad = 0;
        end
        check("edge_found", 32'(bad), 0);
        halt = 1'b1;
        tick();
        check("halt_no_pulse", 32'(cpu_en), 0);
        check("halt_state", 32'(state_o), 3);
        clear_obs();
        halt_clr = 1'b1;
        for (int i = 0; i < 8; i++) observe();
        check("halt_clr_held", 32'(state_o), 3);
        check("halt_pulses", 32'(pulses), 0);
        halt = 1'b0;
        tick();
        check("halt_exit_pause", 32'(state_o), 0);
        halt_clr = 1'b0;

        // 5: async reset while STEP waits for an edge
        run_sw = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        div_on = 1'b0;
        step_btn = 1'b1;
        bad = 1;
        for (int i = 0; i < 20 && bad == 1; i++) begin
            tick();
            if (state_o == 2'd2) bad = 0;
        end
        check("step_wait", 32'(state_o), 2);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_state", 32'(state_o), 0);
        check("async_rst_cpu_en", 32'(cpu_en), 0);
        step_btn = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        div_on = 1'b1;
        clear_obs();
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            observe();
            if (state_o != 2'd0) bad++;
        end
        check("post_rst_pulses", 32'(pulses), 0);
        check("post_rst_state", 32'(bad), 0);

`ifdef TICK_STEP_CTRL_CNT_EN
        // 6: 17 pulses wrap a 4-bit counter to 1
        rst = 1'b1;
        tick();
        check("cnt_rst", 32'(tick_cnt), 0);
        rst = 1'b0;
        run_sw = 1'b1;
        pulses = 0;
        for (int i = 0; i < 300 && pulses < 17; i++) begin
            tick();
            pulses += int'(cpu_en);
        end
        check("cnt_pulses", 32'(pulses), 17);
        tick();
        check("cnt_wrap", 32'(tick_cnt), 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
